// File: rtl/can_bit_destuff.sv
`default_nettype none
// ============================================================================
// Module   : can_bit_destuff
// Brief    : CAN/CAN FD receive de-stuffer. Removes dynamic and FD fixed
//            stuff bits, flags stuff errors and reports the Gray-coded
//            dynamic stuff count with parity.
// Revision : 1.0 - initial release
// ============================================================================
module can_bit_destuff #(
    parameter int TP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_point,
    input  logic       sampled_bit,
    input  logic       destuff_en,
    input  logic       fixed_stuff_mode,
    input  logic       restart,
    output logic       bit_valid,
    output logic       bit_data,
    output logic       stuff_bit,
    output logic       stuff_err,
    output logic       err_hold,
    output logic [2:0] stuff_cnt_gray,
    output logic       stuff_cnt_par
);

    localparam logic [2:0] c_RUN_LIMIT = 3'd5;
    localparam logic [2:0] c_FIX_LIMIT = 3'd4;

    logic       r_last_bit;
    logic [2:0] r_same_cnt;
    logic [2:0] r_dyn_cnt;
    logic [2:0] r_fix_cnt;
    logic       r_fixed_q;
    logic       r_err_hold;

    logic       w_complement;
    logic       w_run_cont;

    assign w_complement = (sampled_bit != r_last_bit);
    assign w_run_cont   = (sampled_bit == r_last_bit) && (r_same_cnt != 3'd0);

    // The registered core is modelled with zero delay; TP only gates elaboration.
    if (TP >= 0) begin : g_core
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                bit_valid  <= 1'b0;
                bit_data   <= 1'b0;
                stuff_bit  <= 1'b0;
                stuff_err  <= 1'b0;
                r_last_bit <= 1'b1;
                r_same_cnt <= 3'd0;
                r_dyn_cnt  <= 3'd0;
                r_fix_cnt  <= 3'd0;
                r_fixed_q  <= 1'b0;
                r_err_hold <= 1'b0;
            end else begin
                bit_valid <= 1'b0;
                stuff_bit <= 1'b0;
                stuff_err <= 1'b0;
                if (restart) begin
                    bit_data   <= 1'b0;
                    r_last_bit <= 1'b1;
                    r_same_cnt <= 3'd0;
                    r_dyn_cnt  <= 3'd0;
                    r_fix_cnt  <= 3'd0;
                    r_fixed_q  <= 1'b0;
                    r_err_hold <= 1'b0;
                end else if (sample_point && !r_err_hold) begin
                    if (!destuff_en) begin
                        bit_valid  <= 1'b1;
                        bit_data   <= sampled_bit;
                        r_last_bit <= 1'b1;
                        r_same_cnt <= 3'd0;
                        r_fix_cnt  <= 3'd0;
                        r_fixed_q  <= 1'b0;
                    end else if (!fixed_stuff_mode) begin
                        // Fixed mode keeps same_cnt at 1, so leaving it resumes with a run of 1.
                        r_fixed_q <= 1'b0;
                        if (r_same_cnt == c_RUN_LIMIT) begin
                            if (w_complement) begin
                                stuff_bit  <= 1'b1;
                                r_dyn_cnt  <= r_dyn_cnt + 3'd1;
                                r_same_cnt <= 3'd1;
                                r_last_bit <= sampled_bit;
                            end else begin
                                stuff_err  <= 1'b1;
                                r_err_hold <= 1'b1;
                            end
                        end else begin
                            bit_valid  <= 1'b1;
                            bit_data   <= sampled_bit;
                            r_same_cnt <= w_run_cont ? (r_same_cnt + 3'd1) : 3'd1;
                            r_last_bit <= sampled_bit;
                        end
                    end else begin
                        r_fixed_q  <= 1'b1;
                        r_same_cnt <= 3'd1;
                        if (!r_fixed_q || (r_fix_cnt == c_FIX_LIMIT)) begin
                            r_fix_cnt <= 3'd0;
                            if (w_complement) begin
                                stuff_bit  <= 1'b1;
                                r_last_bit <= sampled_bit;
                            end else begin
                                stuff_err  <= 1'b1;
                                r_err_hold <= 1'b1;
                            end
                        end else begin
                            bit_valid  <= 1'b1;
                            bit_data   <= sampled_bit;
                            r_fix_cnt  <= r_fix_cnt + 3'd1;
                            r_last_bit <= sampled_bit;
                        end
                    end
                end
            end
        end
    end

    assign err_hold       = r_err_hold;
    assign stuff_cnt_gray = r_dyn_cnt ^ (r_dyn_cnt >> 1);
    assign stuff_cnt_par  = ^stuff_cnt_gray;

endmodule
`default_nettype wire

// File: tb/tb_can_bit_destuff.sv
`default_nettype none
// Self-checking bench for can_bit_destuff: vector table, directed corner
// sequences and randomized traffic against a history-based reference model.
module tb_can_bit_destuff;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_point = 1'b0;
    logic       sampled_bit = 1'b0;
    logic       destuff_en = 1'b0;
    logic       fixed_stuff_mode = 1'b0;
    logic       restart = 1'b0;
    logic       bit_valid, bit_data, stuff_bit, stuff_err, err_hold, stuff_cnt_par;
    logic [2:0] stuff_cnt_gray;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    can_bit_destuff #(.TP(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_point     (sample_point),
        .sampled_bit      (sampled_bit),
        .destuff_en       (destuff_en),
        .fixed_stuff_mode (fixed_stuff_mode),
        .restart          (restart),
        .bit_valid        (bit_valid),
        .bit_data         (bit_data),
        .stuff_bit        (stuff_bit),
        .stuff_err        (stuff_err),
        .err_hold         (err_hold),
        .stuff_cnt_gray   (stuff_cnt_gray),
        .stuff_cnt_par    (stuff_cnt_par)
    );

    // Reference model: bits accepted in the current dynamic segment are kept
    // in a queue; the run length is read off its tail.
    bit hist[$];
    bit m_last, m_fixed, m_hold;
    int m_dyn, m_fix;
    bit e_valid, e_data, e_stuff, e_err;

    task automatic model_reset();
        hist.delete();
        m_last = 1'b1; m_fixed = 1'b0; m_hold = 1'b0;
        m_dyn = 0; m_fix = 0;
        e_valid = 0; e_data = 0; e_stuff = 0; e_err = 0;
    endtask

    function automatic int tail_run();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size()-1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_step(input bit sp, input bit sb, input bit de, input bit fm, input bit rs);
        e_valid = 0; e_stuff = 0; e_err = 0;
        if (rs) begin
            model_reset();
        end else if (sp && !m_hold) begin
            if (!de) begin
                e_valid = 1; e_data = sb;
                m_last = 1; m_fixed = 0; hist.delete();
            end else if (!fm) begin
                if (m_fixed) begin
                    hist.delete();
                    hist.push_back(m_last);
                    m_fixed = 0;
                end
                if (tail_run() == 5) begin
                    if (sb != m_last) begin
                        e_stuff = 1; m_dyn = (m_dyn + 1) % 8;
                        hist.push_back(sb); m_last = sb;
                    end else begin
                        e_err = 1; m_hold = 1;
                    end
                end else begin
                    e_valid = 1; e_data = sb;
                    hist.push_back(sb); m_last = sb;
                end
                if (hist.size() > 12) void'(hist.pop_front());
            end else begin
                if (!m_fixed || m_fix == 4) begin
                    m_fixed = 1; m_fix = 0;
                    if (sb != m_last) begin
                        e_stuff = 1; m_last = sb;
                    end else begin
                        e_err = 1; m_hold = 1;
                    end
                end else begin
                    e_valid = 1; e_data = sb; m_fix++; m_last = sb;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [2:0] g;
        g = 3'(m_dyn ^ (m_dyn >> 1));
        chk({tag, ".bit_valid"}, {7'd0, bit_valid}, {7'd0, e_valid});
        chk({tag, ".stuff_bit"}, {7'd0, stuff_bit}, {7'd0, e_stuff});
        chk({tag, ".stuff_err"}, {7'd0, stuff_err}, {7'd0, e_err});
        chk({tag, ".err_hold"},  {7'd0, err_hold},  {7'd0, m_hold});
        chk({tag, ".gray"},      {5'd0, stuff_cnt_gray}, {5'd0, g});
        chk({tag, ".par"},       {7'd0, stuff_cnt_par},  {7'd0, ^g});
        if (e_valid) chk({tag, ".bit_data"}, {7'd0, bit_data}, {7'd0, e_data});
    endtask

    task automatic step(input bit sp, input bit sb, input bit de, input bit fm, input bit rs);
        sample_point = sp; sampled_bit = sb; destuff_en = de;
        fixed_stuff_mode = fm; restart = rs;
        @(posedge clk);
        model_step(sp, sb, de, fm, rs);
        #1;
    endtask

    task automatic stepm(input bit sp, input bit sb, input bit de, input bit fm, input bit rs, input string tag);
        step(sp, sb, de, fm, rs);
        check_model(tag);
    endtask

    typedef struct packed {
        bit sp, sb, de, fm, rs;
        bit v, d, s, e, h;
        bit [2:0] gray;
        bit par;
    } vec_t;

    function automatic vec_t mk(bit sp, bit sb, bit de, bit fm, bit rs,
                                bit v, bit d, bit s, bit e, bit h, bit [2:0] gray, bit par);
        vec_t x;
        x.sp = sp; x.sb = sb; x.de = de; x.fm = fm; x.rs = rs;
        x.v = v; x.d = d; x.s = s; x.e = e; x.h = h; x.gray = gray; x.par = par;
        return x;
    endfunction

    vec_t vt[25];
    bit [2:0] gray_seq[8];

    initial begin
        bit b, prev, sp, de, fm, rs;

        // Dynamic destuff, stuff error with hold, restart and SOF run restart.
        for (int i = 0; i < 5; i++) vt[i] = mk(1,0,1,0,0, 1,0,0,0,0, 3'b000,0);
        vt[5]  = mk(1,1,1,0,0, 0,0,1,0,0, 3'b001,1);
        vt[6]  = mk(1,0,1,0,0, 1,0,0,0,0, 3'b001,1);
        vt[7]  = mk(0,0,1,0,0, 0,0,0,0,0, 3'b001,1);
        vt[8]  = mk(0,0,1,0,1, 0,0,0,0,0, 3'b000,0);
        vt[9]  = mk(1,1,0,0,0, 1,1,0,0,0, 3'b000,0);
        for (int i = 10; i < 15; i++) vt[i] = mk(1,1,1,0,0, 1,1,0,0,0, 3'b000,0);
        vt[15] = mk(1,1,1,0,0, 0,0,0,1,1, 3'b000,0);
        vt[16] = mk(1,0,1,0,0, 0,0,0,0,1, 3'b000,0);
        vt[17] = mk(0,0,1,0,1, 0,0,0,0,0, 3'b000,0);
        vt[18] = mk(1,1,1,0,1, 0,0,0,0,0, 3'b000,0);
        for (int i = 19; i < 24; i++) vt[i] = mk(1,0,1,0,0, 1,0,0,0,0, 3'b000,0);
        vt[24] = mk(1,1,1,0,0, 0,0,1,0,0, 3'b001,1);

        gray_seq[0] = 3'b001; gray_seq[1] = 3'b011; gray_seq[2] = 3'b010; gray_seq[3] = 3'b110;
        gray_seq[4] = 3'b111; gray_seq[5] = 3'b101; gray_seq[6] = 3'b100; gray_seq[7] = 3'b000;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", {1'b0, bit_valid, bit_data, stuff_bit, stuff_err, err_hold, stuff_cnt_par, 1'b0}, 8'd0);
        chk("reset.gray", {5'd0, stuff_cnt_gray}, 8'd0);
        #2 rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            step(vt[i].sp, vt[i].sb, vt[i].de, vt[i].fm, vt[i].rs);
            chk($sformatf("vec%0d.bit_valid", i), {7'd0, bit_valid}, {7'd0, vt[i].v});
            chk($sformatf("vec%0d.stuff_bit", i), {7'd0, stuff_bit}, {7'd0, vt[i].s});
            chk($sformatf("vec%0d.stuff_err", i), {7'd0, stuff_err}, {7'd0, vt[i].e});
            chk($sformatf("vec%0d.err_hold", i),  {7'd0, err_hold},  {7'd0, vt[i].h});
            chk($sformatf("vec%0d.gray", i), {5'd0, stuff_cnt_gray}, {5'd0, vt[i].gray});
            chk($sformatf("vec%0d.par", i),  {7'd0, stuff_cnt_par},  {7'd0, vt[i].par});
            if (vt[i].v) chk($sformatf("vec%0d.bit_data", i), {7'd0, bit_data}, {7'd0, vt[i].d});
        end

        // Gray wrap across eight correct stuff bits.
        stepm(0,0,1,0,1, "wrap.restart");
        b = 1'b0;
        repeat (5) stepm(1,b,1,0,0, "wrap.data");
        for (int k = 0; k < 8; k++) begin
            stepm(1,~b,1,0,0, "wrap.stuff");
            chk($sformatf("wrap%0d.gray", k), {5'd0, stuff_cnt_gray}, {5'd0, gray_seq[k]});
            b = ~b;
            if (k < 7) repeat (4) stepm(1,b,1,0,0, "wrap.data");
        end

        // Fixed mode: correct pattern, then a wrong fixed stuff bit.
        stepm(0,0,1,0,1, "fix.restart");
        stepm(1,1,1,0,0, "fix.pre");
        stepm(1,0,1,1,0, "fix.lead");
        chk("fix.lead.stuff_bit", {7'd0, stuff_bit}, 8'd1);
        stepm(1,1,1,1,0, "fix.d0"); stepm(1,0,1,1,0, "fix.d1");
        stepm(1,1,1,1,0, "fix.d2"); stepm(1,1,1,1,0, "fix.d3");
        chk("fix.d3.bit_valid", {7'd0, bit_valid}, 8'd1);
        stepm(1,0,1,1,0, "fix.fs");
        chk("fix.fs.stuff_bit", {7'd0, stuff_bit}, 8'd1);
        stepm(1,1,1,0,0, "fix.exit");
        stepm(0,0,1,0,1, "fixw.restart");
        stepm(1,1,1,0,0, "fixw.pre");
        stepm(1,0,1,1,0, "fixw.lead");
        stepm(1,1,1,1,0, "fixw.d0"); stepm(1,0,1,1,0, "fixw.d1");
        stepm(1,1,1,1,0, "fixw.d2"); stepm(1,1,1,1,0, "fixw.d3");
        stepm(1,1,1,1,0, "fixw.bad");
        chk("fixw.bad.stuff_err", {7'd0, stuff_err}, 8'd1);

        // Run of five coinciding with fixed-mode entry.
        stepm(0,0,1,0,1, "coin.restart");
        repeat (5) stepm(1,0,1,0,0, "coin.data");
        stepm(1,1,1,1,0, "coin.lead");
        chk("coin.stuff_bit", {7'd0, stuff_bit}, 8'd1);
        chk("coin.gray", {5'd0, stuff_cnt_gray}, 8'd0);
        stepm(1,1,1,1,0, "coin.d0");
        stepm(1,1,1,0,0, "coin.exit");

        // Asynchronous reset in the middle of a frame with outputs active.
        stepm(0,0,1,0,1, "ar.restart");
        repeat (5) stepm(1,0,1,0,0, "ar.data");
        stepm(1,1,1,0,0, "ar.stuff");
        stepm(1,1,0,0,0, "ar.plain");
        #2 rst = 1'b0;
        #1;
        chk("async.outputs", {1'b0, bit_valid, bit_data, stuff_bit, stuff_err, err_hold, stuff_cnt_par, 1'b0}, 8'd0);
        chk("async.gray", {5'd0, stuff_cnt_gray}, 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic.
        prev = 1'b0; fm = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            sp = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 3) == 0) ? ~prev : prev;
            prev = b;
            de = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 24) == 0) fm = ~fm;
            rs = m_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
            stepm(sp, b, de, fm, rs, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
